// File: rtl/programmable_sequence_generator_pkg.sv
// Shared definitions for the programmable sequence generator:
// FSM state encoding and the configuration field widths.
package programmable_sequence_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int PATTERN_W = 8;
  localparam int LEN_W     = 3;
  localparam int REP_W     = 4;

endpackage

// File: rtl/programmable_sequence_generator_if.sv
// Control and status bundle of the sequence generator.
// The master side configures and starts a run; the slave side is the generator.
interface programmable_sequence_generator_if;
  import programmable_sequence_generator_pkg::*;

  logic                 load;
  logic [PATTERN_W-1:0] pattern_in;
  logic [LEN_W-1:0]     length_in;
  logic [REP_W-1:0]     repeat_in;
  logic                 start;
  logic                 abort;
  logic                 serial_out;
  logic                 valid;
  logic                 busy;
  logic                 done;

  modport master (
    output load, pattern_in, length_in, repeat_in, start, abort,
    input  serial_out, valid, busy, done
  );

  modport slave (
    input  load, pattern_in, length_in, repeat_in, start, abort,
    output serial_out, valid, busy, done
  );

endinterface

// File: rtl/programmable_sequence_generator_counter.sv
// Up-counter with enable and synchronous active-low clear.
// Clear together with enable loads 1, so a count can restart on the same
// edge that consumes its first step.
module programmable_sequence_generator_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetnot,
  input  logic             clear_n,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count register: async reset, sync clear (restart at 1 when enabled), else step.
  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      count_reg <= '0;
    end else if (!clear_n) begin
      count_reg <= enable ? WIDTH'(1) : '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/programmable_sequence_generator.sv
// Serialises a stored 1..8 bit pattern MSB-first, repeated 1..16 times
// back-to-back. All outputs are registered; the first bit appears on the
// same edge that samples start.
module programmable_sequence_generator (
  input  logic                              clock,
  input  logic                              resetnot,
  programmable_sequence_generator_if.slave  bus
);
  import programmable_sequence_generator_pkg::*;

  state_t               state_reg;
  state_t               state_next;

  logic [PATTERN_W-1:0] pattern_reg;
  logic [LEN_W-1:0]     length_reg;
  logic [REP_W-1:0]     repeat_reg;

  // bit_cnt: bits already sent in the current pass (1..8).
  // pass_cnt: pass currently being sent (1..16).
  logic [LEN_W:0]       bit_cnt;
  logic [REP_W:0]       pass_cnt;

  logic                 serial_out_reg, valid_reg, busy_reg, done_reg;
  logic                 serial_out_next, valid_next, busy_next, done_next;

  logic                 load_go, start_go, send_run;
  logic                 bit_last, pass_last, pass_wrap, bit_step;
  logic [PATTERN_W-1:0] eff_pattern;
  logic [LEN_W-1:0]     eff_length;
  logic [LEN_W-1:0]     bit_sel;

  // Load and start only matter in IDLE; a simultaneous load feeds the new run directly.
  assign load_go     = (state_reg == IDLE) && bus.load;
  assign start_go    = (state_reg == IDLE) && bus.start;
  assign eff_pattern = load_go ? bus.pattern_in : pattern_reg;
  assign eff_length  = load_go ? bus.length_in  : length_reg;

  assign send_run  = (state_reg == SEND) && !bus.abort;
  assign bit_last  = (bit_cnt  == ({1'b0, length_reg} + 4'd1));
  assign pass_last = (pass_cnt == ({1'b0, repeat_reg} + 5'd1));
  assign pass_wrap = send_run && bit_last && !pass_last;
  assign bit_step  = send_run && !bit_last;

  // First bit of a pass is pattern[length]; later bits walk down from there.
  assign bit_sel = (start_go || pass_wrap) ? eff_length
                                           : (length_reg - bit_cnt[LEN_W-1:0]);

  programmable_sequence_generator_counter #(.WIDTH(LEN_W + 1)) u_bit_counter (
    .clock    (clock),
    .resetnot (resetnot),
    .clear_n  (!(start_go || pass_wrap)),
    .enable   (start_go || pass_wrap || bit_step),
    .count    (bit_cnt)
  );

  programmable_sequence_generator_counter #(.WIDTH(REP_W + 1)) u_pass_counter (
    .clock    (clock),
    .resetnot (resetnot),
    .clear_n  (!start_go),
    .enable   (start_go || pass_wrap),
    .count    (pass_cnt)
  );

  // Configuration capture, accepted in IDLE only.
  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      pattern_reg <= '0;
      length_reg  <= '0;
      repeat_reg  <= '0;
    end else if (load_go) begin
      pattern_reg <= bus.pattern_in;
      length_reg  <= bus.length_in;
      repeat_reg  <= bus.repeat_in;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetnot) begin
    if (!resetnot) begin
      state_reg      <= IDLE;
      serial_out_reg <= 1'b0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      serial_out_reg <= serial_out_next;
      valid_reg      <= valid_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
    end
  end

  // Next-state logic: abort beats the final bit, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = SEND;
      SEND: begin
        if (bus.abort)                  state_next = IDLE;
        else if (bit_last && pass_last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the state being entered.
  always_comb begin
    serial_out_next = 1'b0;
    valid_next      = 1'b0;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    case (state_next)
      SEND: begin
        serial_out_next = eff_pattern[bit_sel];
        valid_next      = 1'b1;
        busy_next       = 1'b1;
      end
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  assign bus.serial_out = serial_out_reg;
  assign bus.valid      = valid_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_programmable_sequence_generator.sv
// Directed bench for the programmable sequence generator: table of
// configurations with hand-computed bit streams, plus hand-written
// sequences for ignore/abort/reset/128-cycle corner cases.
module tb_programmable_sequence_generator;

  logic clock = 1'b0;
  logic resetnot = 1'b0;

  programmable_sequence_generator_if bus ();

  programmable_sequence_generator dut (
    .clock    (clock),
    .resetnot (resetnot),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  // {valid, busy, done, serial_out}
  localparam logic [3:0] OUT_IDLE = 4'b0000;
  localparam logic [3:0] OUT_DONE = 4'b0010;
  localparam logic [3:0] OUT_ONE  = 4'b1101;
  localparam logic [3:0] OUT_ZERO = 4'b1100;

  typedef struct {
    logic [7:0]  pattern;
    logic [2:0]  length;
    logic [3:0]  rpt;
    bit          load_with_start;
    logic [31:0] stream;   // expected bits, first bit at [nbits-1]
    int          nbits;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [3:0] outs();
    return {bus.valid, bus.busy, bus.done, bus.serial_out};
  endfunction

  task automatic check_out(input string name, input logic [3:0] exp);
    check(name, {28'd0, outs()}, {28'd0, exp});
  endtask

  // All tasks assume they are called just after a falling edge.
  task automatic load_cfg(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
    bus.load = 1'b1;
    bus.pattern_in = p;
    bus.length_in = l;
    bus.repeat_in = r;
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic expect_stream(input string name, input logic [31:0] stream, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      check_out($sformatf("%s_bit%0d", name, i), {3'b110, stream[i]});
      @(negedge clock);
    end
    check_out($sformatf("%s_done", name), OUT_DONE);
    @(negedge clock);
    check_out($sformatf("%s_idle", name), OUT_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int ones;

    vecs[0] = '{8'h0B, 3'd3, 4'd0, 1'b0, 32'h0000000B, 4};
    vecs[1] = '{8'hA5, 3'd7, 4'd2, 1'b0, 32'h00A5A5A5, 24};
    vecs[2] = '{8'h01, 3'd0, 4'd0, 1'b1, 32'h00000001, 1};
    vecs[3] = '{8'h06, 3'd2, 4'd3, 1'b0, 32'h00000DB6, 12};
    vecs[4] = '{8'h5E, 3'd4, 4'd1, 1'b1, 32'h000003DE, 10};
    vecs[5] = '{8'h02, 3'd1, 4'd4, 1'b0, 32'h000002AA, 10};

    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pattern_in = '0;
    bus.length_in = '0;
    bus.repeat_in = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check_out("reset_outputs", OUT_IDLE);
    resetnot = 1'b1;
    @(negedge clock);
    check_out("idle_after_reset", OUT_IDLE);

    // Start with no prior load: single 0 bit then done
    pulse_start();
    expect_stream("no_load", 32'h0, 1);
    $display("txn no_load: single zero bit then done");

    // Table-driven configurations
    for (int k = 0; k < 6; k++) begin
      if (vecs[k].load_with_start) begin
        bus.load = 1'b1;
        bus.pattern_in = vecs[k].pattern;
        bus.length_in = vecs[k].length;
        bus.repeat_in = vecs[k].rpt;
      end else begin
        load_cfg(vecs[k].pattern, vecs[k].length, vecs[k].rpt);
      end
      pulse_start();
      expect_stream($sformatf("vec%0d", k), vecs[k].stream, vecs[k].nbits);
      $display("txn vec%0d: pattern=%h length=%0d repeat=%0d load_with_start=%0d bits=%0d",
               k, vecs[k].pattern, vecs[k].length, vecs[k].rpt, vecs[k].load_with_start, vecs[k].nbits);
    end

    // start/load during SEND and start during DONE are ignored
    load_cfg(8'hA5, 3'd7, 4'd0);
    pulse_start();
    for (int i = 7; i >= 0; i--) begin
      check_out($sformatf("ignore_bit%0d", i), {3'b110, 8'hA5 >> i & 8'h01 ? 1'b1 : 1'b0});
      if (i == 5) begin
        bus.start = 1'b1;
        bus.load = 1'b1;
        bus.pattern_in = 8'hFF;
        bus.length_in = 3'd7;
        bus.repeat_in = 4'd3;
      end else begin
        bus.start = 1'b0;
        bus.load = 1'b0;
      end
      @(negedge clock);
    end
    check_out("ignore_done", OUT_DONE);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check_out("start_in_done_ignored", OUT_IDLE);
    @(negedge clock);
    check_out("no_queued_start", OUT_IDLE);
    pulse_start();
    expect_stream("old_pattern", 32'hA5, 8);
    $display("txn ignore: mid-run start/load and start in DONE ignored");

    // Abort during the 3rd bit
    load_cfg(8'h0B, 3'd3, 4'd0);
    pulse_start();
    check_out("abort3_bit1", OUT_ONE);
    @(negedge clock);
    check_out("abort3_bit2", OUT_ZERO);
    @(negedge clock);
    check_out("abort3_bit3", OUT_ONE);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check_out("abort3_outputs", OUT_IDLE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_out($sformatf("abort3_no_done%0d", i), OUT_IDLE);
    end
    pulse_start();
    expect_stream("after_abort", 32'hB, 4);
    $display("txn abort_mid: abort on bit 3, restart sends 1011");

    // Abort coinciding with the final bit: no done
    pulse_start();
    for (int i = 0; i < 3; i++) @(negedge clock);
    check_out("abort_last_bit4", OUT_ONE);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check_out("abort_last_outputs", OUT_IDLE);
    @(negedge clock);
    check_out("abort_last_no_done", OUT_IDLE);
    $display("txn abort_last: abort wins over final bit");

    // Abort while IDLE is ignored
    bus.abort = 1'b1;
    pulse_start();
    bus.abort = 1'b0;
    expect_stream("abort_idle", 32'hB, 4);
    $display("txn abort_idle: abort with start in IDLE ignored");

    // Maximum run: 8 bits x 16 passes = 128 valid cycles
    load_cfg(8'h81, 3'd7, 4'd15);
    pulse_start();
    n = 0;
    ones = 0;
    while (bus.valid && n < 200) begin
      n++;
      if (bus.serial_out) ones++;
      @(negedge clock);
    end
    check("max_valid_cycles", 32'(n), 32'd128);
    check("max_one_bits", 32'(ones), 32'd32);
    check_out("max_done", OUT_DONE);
    @(negedge clock);
    check_out("max_idle", OUT_IDLE);
    $display("txn max_run: valid_cycles=%0d ones=%0d", n, ones);

    // Asynchronous reset between edges during SEND
    load_cfg(8'hA5, 3'd7, 4'd2);
    pulse_start();
    repeat (5) @(negedge clock);
    check_out("pre_reset_busy", OUT_ONE);
    #2;
    resetnot = 1'b0;
    #1;
    check_out("async_reset_outputs", OUT_IDLE);
    @(negedge clock);
    resetnot = 1'b1;
    @(negedge clock);
    check_out("post_reset_idle", OUT_IDLE);
    pulse_start();
    expect_stream("post_reset", 32'h0, 1);
    $display("txn async_reset: outputs cleared mid-run, config cleared");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
